// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction/extension and
// register-file write port back into decode, plus HALT detection and retire stats.
module wb_stage #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int NB_PC    = 32,
  parameter int NB_COUNT = 32
) (
  input  logic                i_WB_clock,
  input  logic                i_WB_reset,
  input  logic                i_WB_enable,
  input  logic                i_WB_flush,
  input  logic                i_WB_valid,
  input  logic                i_WB_reg_write,
  input  logic                i_WB_mem_to_reg,
  input  logic [NB_DATA-1:0]  i_WB_alu_result,
  input  logic [NB_DATA-1:0]  i_WB_mem_data,
  input  logic [2:0]          i_WB_load_type,
  input  logic [1:0]          i_WB_byte_offset,
  input  logic [NB_REG-1:0]   i_WB_write_reg,
  input  logic [NB_PC-1:0]    i_WB_pc,
  input  logic                i_WB_halt,
  output logic [NB_DATA-1:0]  o_WB_write_data,
  output logic [NB_REG-1:0]   o_WB_write_reg,
  output logic                o_WB_reg_write,
  output logic                o_WB_halted,
  output logic [NB_COUNT-1:0] o_WB_retired_count,
  output logic [NB_PC-1:0]    o_WB_last_pc
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state, state_next;

  logic               valid_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;
  logic [NB_DATA-1:0] alu_q;
  logic [NB_DATA-1:0] mem_q;
  logic [2:0]         load_type_q;
  logic [1:0]         offset_q;
  logic [NB_REG-1:0]  write_reg_q;
  logic [NB_COUNT-1:0] count_q;
  logic [NB_PC-1:0]   last_pc_q;

  logic advance;
  logic take;
  logic take_halt;

  // A slot is only accepted while running and not stalled; flush turns it into a bubble.
  assign advance   = i_WB_enable && (state == RUN);
  assign take      = advance && !i_WB_flush && i_WB_valid;
  assign take_halt = take && i_WB_halt;

  always_comb begin
    state_next = state;
    if (state == RUN && take_halt) state_next = HALTED;
  end

  always_ff @(posedge i_WB_clock or negedge i_WB_reset) begin
    if (!i_WB_reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_WB_clock or negedge i_WB_reset) begin
    if (!i_WB_reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_q        <= '0;
      mem_q        <= '0;
      load_type_q  <= '0;
      offset_q     <= '0;
      write_reg_q  <= '0;
    end else if (advance) begin
      if (i_WB_flush) begin
        valid_q      <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
        alu_q        <= '0;
        mem_q        <= '0;
        load_type_q  <= '0;
        offset_q     <= '0;
        write_reg_q  <= '0;
      end else begin
        // A HALT occupies the slot but must never write the register file.
        valid_q      <= i_WB_valid && !i_WB_halt;
        reg_write_q  <= i_WB_reg_write;
        mem_to_reg_q <= i_WB_mem_to_reg;
        alu_q        <= i_WB_alu_result;
        mem_q        <= i_WB_mem_data;
        load_type_q  <= i_WB_load_type;
        offset_q     <= i_WB_byte_offset;
        write_reg_q  <= i_WB_write_reg;
      end
    end
  end

  always_ff @(posedge i_WB_clock or negedge i_WB_reset) begin
    if (!i_WB_reset) begin
      count_q   <= '0;
      last_pc_q <= '0;
    end else if (take) begin
      last_pc_q <= i_WB_pc;
      if (!i_WB_halt && count_q != {NB_COUNT{1'b1}}) count_q <= count_q + NB_COUNT'(1);
    end
  end

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [NB_DATA-1:0] load_data;

  // Little-endian lane select; halfword ignores offset bit 0.
  always_comb begin
    byte_sel  = mem_q[7:0];
    half_sel  = offset_q[1] ? mem_q[31:16] : mem_q[15:0];
    load_data = mem_q;
    case (offset_q)
      2'd0: byte_sel = mem_q[7:0];
      2'd1: byte_sel = mem_q[15:8];
      2'd2: byte_sel = mem_q[23:16];
      2'd3: byte_sel = mem_q[31:24];
      default: byte_sel = mem_q[7:0];
    endcase
    case (load_type_q)
      3'b000: load_data = {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
      3'b001: load_data = {{(NB_DATA-16){half_sel[15]}}, half_sel};
      3'b100: load_data = {{(NB_DATA-8){1'b0}}, byte_sel};
      3'b101: load_data = {{(NB_DATA-16){1'b0}}, half_sel};
      default: load_data = mem_q;
    endcase
  end

  assign o_WB_write_data    = mem_to_reg_q ? load_data : alu_q;
  assign o_WB_write_reg     = write_reg_q;
  assign o_WB_reg_write     = valid_q && reg_write_q && (write_reg_q != '0) &&
                              i_WB_enable && (state == RUN);
  assign o_WB_halted        = (state == HALTED);
  assign o_WB_retired_count = count_q;
  assign o_WB_last_pc       = last_pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: driver pushes hand-computed expectations into a
// queue, a monitor pops and compares them mid-cycle (or on an async-reset event).
module tb_wb_stage;

  localparam int EXP_W = 104;

  logic        clk;
  logic        rst_n;
  logic        enable, flush, valid, reg_write, mem_to_reg, halt;
  logic [31:0] alu_result, mem_data, pc;
  logic [2:0]  load_type;
  logic [1:0]  byte_offset;
  logic [4:0]  write_reg;
  logic [31:0] o_write_data;
  logic [4:0]  o_write_reg;
  logic        o_reg_write;
  logic        o_halted;
  logic [31:0] o_count;
  logic [31:0] o_last_pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  event sample_ev;

  wb_stage dut (
    .i_WB_clock         (clk),
    .i_WB_reset         (rst_n),
    .i_WB_enable        (enable),
    .i_WB_flush         (flush),
    .i_WB_valid         (valid),
    .i_WB_reg_write     (reg_write),
    .i_WB_mem_to_reg    (mem_to_reg),
    .i_WB_alu_result    (alu_result),
    .i_WB_mem_data      (mem_data),
    .i_WB_load_type     (load_type),
    .i_WB_byte_offset   (byte_offset),
    .i_WB_write_reg     (write_reg),
    .i_WB_pc            (pc),
    .i_WB_halt          (halt),
    .o_WB_write_data    (o_write_data),
    .o_WB_write_reg     (o_write_reg),
    .o_WB_reg_write     (o_reg_write),
    .o_WB_halted        (o_halted),
    .o_WB_retired_count (o_count),
    .o_WB_last_pc       (o_last_pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: layout {chk_write, rw, reg[4:0], data[31:0], halted, count[31:0], last_pc[31:0]}
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk or sample_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("reg_write", {31'b0, o_reg_write}, {31'b0, e[102]});
        if (e[103]) begin
          check("write_reg", {27'b0, o_write_reg}, {27'b0, e[101:97]});
          check("write_data", o_write_data, e[96:65]);
        end
        check("halted", {31'b0, o_halted}, {31'b0, e[64]});
        check("retired_count", o_count, e[63:32]);
        check("last_pc", o_last_pc, e[31:0]);
      end
    end
  end

  task automatic push_exp(input logic chk, input logic e_rw, input logic [4:0] e_reg,
                          input logic [31:0] e_data, input logic e_h,
                          input logic [31:0] e_cnt, input logic [31:0] e_pc);
    exp_q.push_back({chk, e_rw, e_reg, e_data, e_h, e_cnt, e_pc});
  endtask

  task automatic idle();
    enable = 1'b1; flush = 1'b0; valid = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    halt = 1'b0; alu_result = '0; mem_data = '0; pc = '0; load_type = '0;
    byte_offset = '0; write_reg = '0;
  endtask

  // Driver: inputs stay applied through the sampling point after the edge.
  task automatic step(input logic en, input logic fl, input logic v, input logic rw,
                      input logic m2r, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [2:0] lt, input logic [1:0] off, input logic [4:0] wr,
                      input logic [31:0] p, input logic hl,
                      input logic chk, input logic e_rw, input logic [4:0] e_reg,
                      input logic [31:0] e_data, input logic e_h,
                      input logic [31:0] e_cnt, input logic [31:0] e_pc);
    enable = en; flush = fl; valid = v; reg_write = rw; mem_to_reg = m2r;
    alu_result = alu; mem_data = mem; load_type = lt; byte_offset = off;
    write_reg = wr; pc = p; halt = hl;
    @(posedge clk);
    push_exp(chk, e_rw, e_reg, e_data, e_h, e_cnt, e_pc);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    push_exp(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1 -> sample_ev;
    #1;
    idle();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  localparam logic [31:0] MD = 32'h80FF_7F81;

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    push_exp(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    -> sample_ev;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    //   en fl v rw m2r alu           mem  lt      off  wr     pc            hl | chk rw reg   data          h  cnt    last_pc
    step(1, 0, 1, 1, 0, 32'h0000_1234, 32'h0, 3'b010, 2'd0, 5'd5,  32'h100, 0,  1, 1, 5'd5,  32'h0000_1234, 0, 32'd1,  32'h100);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b000, 2'd0, 5'd6,  32'h104, 0,  1, 1, 5'd6,  32'hFFFF_FF81, 0, 32'd2,  32'h104);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b100, 2'd0, 5'd7,  32'h108, 0,  1, 1, 5'd7,  32'h0000_0081, 0, 32'd3,  32'h108);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b000, 2'd1, 5'd8,  32'h10C, 0,  1, 1, 5'd8,  32'h0000_007F, 0, 32'd4,  32'h10C);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b001, 2'd2, 5'd9,  32'h110, 0,  1, 1, 5'd9,  32'hFFFF_80FF, 0, 32'd5,  32'h110);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b101, 2'd2, 5'd10, 32'h114, 0,  1, 1, 5'd10, 32'h0000_80FF, 0, 32'd6,  32'h114);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b010, 2'd0, 5'd11, 32'h118, 0,  1, 1, 5'd11, 32'h80FF_7F81, 0, 32'd7,  32'h118);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b001, 2'd3, 5'd12, 32'h11C, 0,  1, 1, 5'd12, 32'hFFFF_80FF, 0, 32'd8,  32'h11C);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b000, 2'd3, 5'd13, 32'h120, 0,  1, 1, 5'd13, 32'hFFFF_FF80, 0, 32'd9,  32'h120);
    step(1, 0, 1, 1, 1, 32'hDEAD_0000, MD,   3'b111, 2'd1, 5'd14, 32'h122, 0,  1, 1, 5'd14, 32'h80FF_7F81, 0, 32'd10, 32'h122);
    // $zero destination: counted, never written
    step(1, 0, 1, 1, 0, 32'h0000_0055, 32'h0, 3'b010, 2'd0, 5'd0,  32'h124, 0,  1, 0, 5'd0,  32'h0000_0055, 0, 32'd11, 32'h124);
    step(1, 0, 1, 1, 0, 32'h0000_AAAA, 32'h0, 3'b010, 2'd0, 5'd3,  32'h128, 0,  1, 1, 5'd3,  32'h0000_AAAA, 0, 32'd12, 32'h128);
    // Stall: latched write held, write enable gated off
    step(0, 0, 1, 1, 0, 32'h0000_9999, 32'h0, 3'b010, 2'd0, 5'd4,  32'h12C, 0,  1, 0, 5'd3,  32'h0000_AAAA, 0, 32'd12, 32'h128);
    step(1, 0, 1, 1, 0, 32'h0000_9999, 32'h0, 3'b010, 2'd0, 5'd4,  32'h12C, 0,  1, 1, 5'd4,  32'h0000_9999, 0, 32'd13, 32'h12C);
    // Flush turns a valid instruction into a bubble
    step(1, 1, 1, 1, 0, 32'h0000_7777, 32'h0, 3'b010, 2'd0, 5'd20, 32'h130, 0,  0, 0, 5'd0,  32'h0,         0, 32'd13, 32'h12C);
    step(1, 0, 1, 1, 0, 32'h0000_4242, 32'h0, 3'b010, 2'd0, 5'd9,  32'h200, 0,  1, 1, 5'd9,  32'h0000_4242, 0, 32'd14, 32'h200);

    // Async reset with a write latched and inputs still active
    async_reset_check();

    step(1, 0, 1, 1, 0, 32'h0000_0011, 32'h0, 3'b010, 2'd0, 5'd1,  32'h000, 0,  1, 1, 5'd1,  32'h0000_0011, 0, 32'd1,  32'h000);
    step(1, 0, 1, 1, 0, 32'h0000_0022, 32'h0, 3'b010, 2'd0, 5'd2,  32'h004, 0,  1, 1, 5'd2,  32'h0000_0022, 0, 32'd2,  32'h004);
    step(1, 0, 1, 1, 0, 32'h0000_0033, 32'h0, 3'b010, 2'd0, 5'd3,  32'h008, 0,  1, 1, 5'd3,  32'h0000_0033, 0, 32'd3,  32'h008);
    // HALT together with flush: flush wins
    step(1, 1, 1, 0, 0, 32'h0,         32'h0, 3'b010, 2'd0, 5'd0,  32'h030, 1,  0, 0, 5'd0,  32'h0,         0, 32'd3,  32'h008);
    step(1, 0, 1, 0, 0, 32'h0,         32'h0, 3'b010, 2'd0, 5'd0,  32'h040, 1,  0, 0, 5'd0,  32'h0,         1, 32'd3,  32'h040);
    step(1, 0, 1, 1, 0, 32'h0000_1111, 32'h0, 3'b010, 2'd0, 5'd5,  32'h044, 0,  0, 0, 5'd0,  32'h0,         1, 32'd3,  32'h040);
    step(1, 0, 1, 1, 0, 32'h0000_2222, 32'h0, 3'b010, 2'd0, 5'd6,  32'h048, 0,  0, 0, 5'd0,  32'h0,         1, 32'd3,  32'h040);

    idle();
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
